// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the sequential descending sorter.
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_sorter_if.sv
// Input and output valid/ready streams of the sorter plus its busy flag.
interface seq_sorter_if #(
  parameter int unsigned W = 8
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );

endinterface

// File: rtl/cx_unit.sv
// Combinational compare-exchange: hi/lo ordered largest first, swap when b wins strictly.
module cx_unit #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         swap
);

  assign swap = (b > a);
  assign hi   = swap ? b : a;
  assign lo   = swap ? a : b;

endmodule

// File: rtl/seq_sorter.sv
// Sequential bubble sorter: load M words, sort in place with one shared
// compare-exchange unit, then stream them out largest first.
module seq_sorter
  import sort_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned M = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_sorter_if.slave bus
);

  localparam int unsigned CW = cnt_w(M);
  localparam int unsigned KW = cnt_w(M - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wr_q, wr_d;
  logic [CW-1:0] rd_q, rd_d;
  logic [CW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  logic          swp_q, swp_d;
  logic [W-1:0]  buf_q [M];
  logic [W-1:0]  buf_d [M];

  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          busy_q, busy_d;
  logic [W-1:0]  out_data_q, out_data_d;

  logic [CW-1:0] j_nxt;
  logic [CW-1:0] last_j;
  logic [W-1:0]  cx_hi, cx_lo;
  logic          cx_swap;
  logic          swp_now;
  logic          pass_end;

  assign j_nxt  = j_q + CW'(1);
  assign last_j = CW'(M - 2) - CW'(k_q);

  cx_unit #(.W(W)) u_cx (
    .a    (buf_q[j_q]),
    .b    (buf_q[j_nxt]),
    .hi   (cx_hi),
    .lo   (cx_lo),
    .swap (cx_swap)
  );

  // Next-state, counter and buffer write-back logic.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    j_d      = j_q;
    k_d      = k_q;
    swp_d    = swp_q;
    buf_d    = buf_q;
    swp_now  = swp_q | cx_swap;
    pass_end = (j_q == last_j);

    unique case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          buf_d[wr_q] = bus.in_data;
          if (wr_q == CW'(M - 1)) begin
            state_d = SORT;
            wr_d    = '0;
            j_d     = '0;
            k_d     = '0;
            swp_d   = 1'b0;
          end else begin
            wr_d = wr_q + CW'(1);
          end
        end
      end
      SORT: begin
        if (cx_swap) begin
          buf_d[j_q]   = cx_hi;
          buf_d[j_nxt] = cx_lo;
        end
        if (pass_end) begin
          // Last pass done, or a swap-free pass proves the buffer is ordered.
          if ((k_q == KW'(M - 2)) || !swp_now) begin
            state_d = DRAIN;
            rd_d    = '0;
            j_d     = '0;
            k_d     = '0;
            swp_d   = 1'b0;
          end else begin
            k_d   = k_q + KW'(1);
            j_d   = '0;
            swp_d = 1'b0;
          end
        end else begin
          j_d   = j_nxt;
          swp_d = swp_now;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (rd_q == CW'(M - 1)) begin
            state_d = LOAD;
            rd_d    = '0;
            wr_d    = '0;
          end else begin
            rd_d = rd_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Outputs are registered from the next state so they carry no input-to-output path.
  always_comb begin
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == DRAIN);
    busy_d      = (state_d != LOAD);
    out_last_d  = (state_d == DRAIN) && (rd_d == CW'(M - 1));
    out_data_d  = (state_d == DRAIN) ? buf_d[rd_d] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      wr_q        <= '0;
      rd_q        <= '0;
      j_q         <= '0;
      k_q         <= '0;
      swp_q       <= 1'b0;
      buf_q       <= '{default: '0};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      j_q         <= j_d;
      k_q         <= k_d;
      swp_q       <= swp_d;
      buf_q       <= buf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: doc/seq_sorter.md
# seq_sorter

Sequential descending sorter that schedules one shared compare-exchange unit across an M-entry buffer instead of instantiating a full comparator network. It accepts M words over a valid/ready input stream and sorts them in place with a bubble-sort schedule (one compare per cycle, early exit on a swap-free pass). It then streams the result out largest-first over a valid/ready output stream. It sits between a producer and a consumer where area matters more than throughput.

## Interface
- `W`, 8, data word width in bits
- `M`, 8, elements per batch; legal values are M ≥ 2
- `clk`  in  1  sole clock; rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  producer has a word
- `in_ready`  out  1  sorter accepts a word this cycle
- `in_data`  in  W  unsigned input word
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  consumer accepts a word
- `out_data`  out  W  sorted word, largest first
- `out_last`  out  1  high with the M-th output word
- `busy`  out  1  high in SORT and DRAIN

## Operation
- FSM states are LOAD, SORT and DRAIN. Reset enters LOAD.
- LOAD
  - `in_ready`=1.
  - On each `in_valid&&in_ready`, `buf[wr]`←`in_data` and `wr`++.
  - On the M-th handshake, go to SORT with `wr`=0, `j`=0, `k`=0, `swp`=0.
- SORT: one compare-exchange per cycle on `buf[j]` and `buf[j+1]`.
  - Comparison is unsigned and strict: if `buf[j+1] > buf[j]`, swap the two entries and set `swp`. Otherwise leave them unchanged.
  - Equal values never swap, so the sort is stable.
  - Pass k covers j = 0 … M-2-k.
- End of pass (j == M-2-k):
  - If k == M-2, or no swap occurred anywhere in the pass (including this cycle), go to DRAIN with `rd`=0.
  - Otherwise k++, j=0, `swp`=0.
- DRAIN
  - `out_valid`=1, `out_data`=`buf[rd]`, `out_last`=(rd==M-1).
  - On `out_valid&&out_ready`, `rd`++.
  - On the handshake with `out_last`, go to LOAD.
- `in_ready`=0 outside LOAD. `out_valid`=0 outside DRAIN.
- Counters `wr`, `rd` and `j` are $clog2(M) bits wide. `k` is $clog2(M-1) bits wide, minimum 1. Counters never wrap past M-1; all counters clear on state entry.

## Timing
- Reset values:
  - state=LOAD, all counters=0, `swp`=0.
  - `buf` entries all 0.
  - `in_ready`=1, `out_valid`=0, `out_last`=0, `busy`=0, `out_data`=0.
- All outputs are registered or decoded from state and counters only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Load takes M accepted handshakes. Producer stalls (`in_valid`=0) insert idle cycles with no state change.
- The first SORT cycle immediately follows the cycle of the M-th input handshake.
- Sort duration:
  - Best case, input already non-increasing: M-1 cycles (one pass).
  - Worst case, strictly increasing input: M(M-1)/2 cycles.
- DRAIN
  - `out_valid` rises the cycle after the final compare.
  - `out_data` holds stable while `out_valid && !out_ready`.
  - Back-to-back handshakes give one word per cycle.
- After the last output handshake, `in_ready`=1 on the next cycle. A new batch cannot overlap draining.
- Asserting `rst_n` low in any state immediately forces the reset values above. A partial batch is discarded.
- `in_valid` is ignored while not in LOAD; an input word offered then is not consumed.

## Structure
- Package `sort_pkg`: state enum (LOAD, SORT, DRAIN).
- Sub-module `cx_unit #(W)`:
  - Inputs: a, b.
  - Outputs: hi = (b>a)?b:a, lo = (b>a)?a:b, swap = (b>a).
  - Purely combinational; exactly one instance, fed from `buf[j]` and `buf[j+1]`.
- Top level holds the FSM, counters, the `buf` register array and the write-back of hi/lo to `buf[j]`/`buf[j+1]`.

## Test plan
- M=4, W=8: load 1,2,3,4 with no stalls → SORT lasts exactly 6 cycles; output 4,3,2,1; `out_last` only on the 1.
- M=4: load 9,7,5,3 → SORT lasts exactly 3 cycles; output 9,7,5,3.
- M=4: load 5,5,2,5 → output 5,5,5,2. An equal pair never reports swap. SORT ends after pass 1 (3+2 cycles).
- M=8: random `in_valid` and `out_ready` with about 50% duty, 100 batches → each batch equals a reference descending sort. `out_data` is stable under stall. `in_ready`=0 for the whole of SORT and DRAIN.
- Pull `rst_n` low mid-SORT, then mid-DRAIN after 2 outputs → same cycle: `out_valid`=0 and `busy`=0; `in_ready`=1 once `rst_n` is released. The next batch 0,255,1,254 sorts to 255,254,1,0.
- M=2: load 3,200 → 1 SORT cycle; output 200,3.
